// File: rtl/invaes_round_ctrl.sv
// AES round sequencer: synchronises load, expands the key one word per cycle, then INIT/ROUND/FINAL, then done.
// Outputs are registered and start 3 edges after load falls; a load rise while busy aborts to IDLE.
module invaes_round_ctrl #(
  parameter int K = 192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dir,
  output logic       kx_en,
  output logic [5:0] kx_word,
  output logic       rnd_en,
  output logic [3:0] rk_idx,
  output logic       first,
  output logic       last,
  output logic       busy,
  output logic       done
);

  localparam int NK = K / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] KW_FIRST  = 6'(NK);
  localparam logic [5:0] KW_LAST   = 6'(NW - 1);
  localparam logic [3:0] RK_MAX    = 4'(NR);
  localparam logic [3:0] RCNT_LAST = 4'(NR - 1);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("invaes_round_ctrl: K must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPAND,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t     state;
  logic       ld_m, ld_s, ld_q;
  logic       dir_q;
  logic [3:0] rcnt;
  logic       start, rise;

  // load is asynchronous to clk; only ld_s and ld_q are used by the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_m <= 1'b0;
      ld_s <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      ld_m <= load;
      ld_s <= ld_m;
      ld_q <= ld_s;
    end
  end

  assign start = ~ld_s & ld_q;
  assign rise  = ld_s & ~ld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      dir_q   <= 1'b0;
      rcnt    <= 4'd0;
      kx_en   <= 1'b0;
      kx_word <= 6'd0;
      rnd_en  <= 1'b0;
      rk_idx  <= 4'd0;
      first   <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (busy && rise) begin
      // abort: kx_word keeps its value, everything else returns to idle
      state  <= S_IDLE;
      kx_en  <= 1'b0;
      rnd_en <= 1'b0;
      rk_idx <= 4'd0;
      first  <= 1'b0;
      last   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_EXPAND;
            dir_q   <= dir;
            kx_en   <= 1'b1;
            kx_word <= KW_FIRST;
            busy    <= 1'b1;
          end
        end
        S_EXPAND: begin
          if (kx_word == KW_LAST) begin
            state  <= S_INIT;
            kx_en  <= 1'b0;
            first  <= 1'b1;
            rnd_en <= 1'b1;
            rk_idx <= dir_q ? RK_MAX : 4'd0;
          end else begin
            kx_word <= kx_word + 6'd1;
          end
        end
        S_INIT: begin
          state  <= S_ROUND;
          first  <= 1'b0;
          rcnt   <= 4'd1;
          rk_idx <= dir_q ? (RK_MAX - 4'd1) : 4'd1;
        end
        S_ROUND: begin
          if (rcnt == RCNT_LAST) begin
            state  <= S_FINAL;
            last   <= 1'b1;
            rk_idx <= dir_q ? 4'd0 : RK_MAX;
          end else begin
            rcnt   <= rcnt + 4'd1;
            rk_idx <= dir_q ? (rk_idx - 4'd1) : (rk_idx + 4'd1);
          end
        end
        S_FINAL: begin
          state  <= S_DONE;
          last   <= 1'b0;
          rnd_en <= 1'b0;
          rk_idx <= 4'd0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        S_DONE: begin
          if (rise) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_invaes_round_ctrl.sv
// Bench for invaes_round_ctrl: one instance per key size, per-cycle expected outputs queued from a cycle-number model.
module tb_invaes_round_ctrl;

  typedef struct packed {
    logic       kx_en;
    logic [5:0] kx_word;
    logic       rnd_en;
    logic [3:0] rk_idx;
    logic       first;
    logic       last;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    string name;
    int    sel;
    bit    d;
    bit    tog;
    int    done_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic reset, load, dir;
  always #5 clk = ~clk;

  logic       kx_en_a   [3];
  logic [5:0] kx_word_a [3];
  logic       rnd_en_a  [3];
  logic [3:0] rk_idx_a  [3];
  logic       first_a   [3];
  logic       last_a    [3];
  logic       busy_a    [3];
  logic       done_a    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    invaes_round_ctrl #(.K(128 + 64 * g)) u_dut (
      .clk(clk), .reset(reset), .load(load), .dir(dir),
      .kx_en(kx_en_a[g]), .kx_word(kx_word_a[g]), .rnd_en(rnd_en_a[g]),
      .rk_idx(rk_idx_a[g]), .first(first_a[g]), .last(last_a[g]),
      .busy(busy_a[g]), .done(done_a[g])
    );
  end

  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  bit   tog = 1'b0;
  obs_t sbq[$];
  vec_t vecs[6];

  // Expected outputs at cycle c of a run (cycle 0 = first EXPAND cycle)
  function automatic obs_t exp_at(int c, int nk, bit d);
    int nr, nw, ne, i;
    obs_t e;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    ne = nw - nk;
    e = '0;
    if (c < ne) begin
      e.kx_en = 1'b1; e.kx_word = 6'(nk + c); e.busy = 1'b1;
    end else begin
      e.kx_word = 6'(nw - 1);
      if (c == ne) begin
        e.first = 1'b1; e.rnd_en = 1'b1; e.busy = 1'b1;
        e.rk_idx = d ? 4'(nr) : 4'd0;
      end else if (c < ne + nr) begin
        i = c - ne;
        e.rnd_en = 1'b1; e.busy = 1'b1;
        e.rk_idx = d ? 4'(nr - i) : 4'(i);
      end else if (c == ne + nr) begin
        e.last = 1'b1; e.rnd_en = 1'b1; e.busy = 1'b1;
        e.rk_idx = d ? 4'd0 : 4'(nr);
      end else begin
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic obs_t get_obs(int s);
    obs_t o;
    o.kx_en = kx_en_a[s];  o.kx_word = kx_word_a[s]; o.rnd_en = rnd_en_a[s];
    o.rk_idx = rk_idx_a[s]; o.first = first_a[s];    o.last = last_a[s];
    o.busy = busy_a[s];    o.done = done_a[s];
    return o;
  endfunction

  task automatic chk_obs(string name, int cyc, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got en=%b w=%0d rnd=%b rk=%0d f=%b l=%b b=%b d=%b, want en=%b w=%0d rnd=%b rk=%0d f=%b l=%b b=%b d=%b",
               name, cyc, act.kx_en, act.kx_word, act.rnd_en, act.rk_idx, act.first, act.last, act.busy, act.done,
               exp.kx_en, exp.kx_word, exp.rnd_en, exp.rk_idx, exp.first, exp.last, exp.busy, exp.done);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic pop_cmp(string name, int cyc, output obs_t o);
    @(negedge clk);
    o = get_obs(sel);
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s cyc %0d: scoreboard empty", name, cyc);
    end else begin
      chk_obs(name, cyc, o, sbq.pop_front());
    end
  endtask

  // Leaves the bench just after the edge that enters EXPAND
  task automatic start_run();
    @(negedge clk);
    load = 1'b1;
    repeat (10) @(negedge clk);
    load = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_full(string name, int s, bit d, bit t, int dc);
    int   nk, first_done;
    obs_t o, idle;
    nk = 4 + 2 * s;
    sel = s;
    dir = d;
    start_run();
    if (t) tog = 1'b1;
    for (int c = 0; c < dc + 4; c++) sbq.push_back(exp_at(c, nk, d));
    idle = '0;
    idle.kx_word = 6'(4 * (nk + 7) - 1);
    sbq.push_back(idle);
    first_done = -1;
    for (int c = 0; c < dc + 2; c++) begin
      pop_cmp(name, c, o);
      if (o.done && first_done < 0) first_done = c;
    end
    tog = 1'b0;
    load = 1'b1;
    for (int c = dc + 2; c < dc + 5; c++) pop_cmp(name, c, o);
    chk_int({name, "_done_cycle"}, first_done, dc);
  endtask

  initial begin : toggler
    forever begin
      @(negedge clk);
      if (tog) dir = ~dir;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    obs_t o, ab;
    int   first_done;

    vecs[0] = '{"k128_dec",     0, 1'b1, 1'b0, 51};
    vecs[1] = '{"k256_enc",     2, 1'b0, 1'b0, 67};
    vecs[2] = '{"k192_enc",     1, 1'b0, 1'b0, 59};
    vecs[3] = '{"k192_dec",     1, 1'b1, 1'b0, 59};
    vecs[4] = '{"k128_dec_tog", 0, 1'b1, 1'b1, 51};
    vecs[5] = '{"k128_enc",     0, 1'b0, 1'b0, 51};

    // Reset with load held high: everything idle, no start
    reset = 1'b1; load = 1'b1; dir = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) chk_obs("reset_state", 0, get_obs(s), '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) chk_obs("load_held_high", c, get_obs(s), '0);
    end

    foreach (vecs[i]) run_full(vecs[i].name, vecs[i].sel, vecs[i].d, vecs[i].tog, vecs[i].done_cyc);

    // Abort mid-EXPAND for K=192: rise at cycle 20, IDLE from cycle 23
    sel = 1; dir = 1'b1;
    start_run();
    for (int c = 0; c < 23; c++) sbq.push_back(exp_at(c, 6, 1'b1));
    ab = '0;
    ab.kx_word = 6'(6 + 22);
    for (int c = 23; c < 63; c++) sbq.push_back(ab);
    for (int c = 0; c < 21; c++) pop_cmp("abort", c, o);
    load = 1'b1;
    first_done = -1;
    for (int c = 21; c < 63; c++) begin
      pop_cmp("abort", c, o);
      if (o.done && first_done < 0) first_done = c;
    end
    chk_int("abort_no_done", first_done, -1);
    run_full("k192_restart", 1, 1'b1, 1'b0, 59);

    // Asynchronous reset inside ROUND of a K=128 run
    sel = 0; dir = 1'b1;
    start_run();
    for (int c = 0; c < 46; c++) sbq.push_back(exp_at(c, 4, 1'b1));
    for (int c = 0; c < 46; c++) pop_cmp("pre_reset", c, o);
    #1 reset = 1'b1;
    #1 chk_obs("async_reset", 45, get_obs(0), '0);
    @(negedge clk);
    reset = 1'b0;
    run_full("k128_after_reset", 0, 1'b1, 1'b0, 51);

    chk_int("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/invaes_round_ctrl.md
Name: invaes_round_ctrl

Overview:
- Sequencing controller for the AES decryption/encryption datapath.
- Synchronizes the Pi chip-enable and detects the end of SPI loading, then runs key expansion one word per cycle.
- Steps the round datapath through the initial AddRoundKey, the middle rounds and the final round, presenting the correct round-key index each cycle.
- Raises done when the result is valid. Sits between the SPI front-end and the core datapath, replacing ad-hoc sequencing inside the core.

Parameters:
- K, 192, key length in bits. Legal values are 128, 192 and 256; any other value must fail elaboration.
- NK (derived), K/32, key length in words: 4 / 6 / 8.
- NR (derived), NK+6, number of rounds: 10 / 12 / 14.
- NW (derived), 4*(NR+1), expanded-key words: 44 / 52 / 60.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- load  in  1  raw Pi chip-enable; high while key/text are shifted in; asynchronous to clk
- dir  in  1  1 = decrypt (inverse cipher), 0 = encrypt; sampled at start
- kx_en  out  1  key-expansion write enable for the current word
- kx_word  out  6  expanded-key word index being generated
- rnd_en  out  1  round datapath update enable
- rk_idx  out  4  round-key index the datapath reads this cycle
- first  out  1  initial AddRoundKey cycle (state load from input text)
- last  out  1  final round: skip (Inv)MixColumns
- busy  out  1  operation in progress
- done  out  1  result valid

Behaviour:
- Reset (async, active-high): state IDLE, synchronizer flops cleared, all outputs 0, dir_q=0, counters 0.
- load passes through a 2-flop synchronizer, then a registered edge detector (ld_q). start = ~ld_s & ld_q, i.e. a falling edge.
- States:
  - IDLE: wait for start.
  - EXPAND: kx_en=1, kx_word runs NK..NW-1, one per cycle.
  - INIT: first=1, rnd_en=1.
  - ROUND: rnd_en=1, for NR-1 cycles.
  - FINAL: last=1, rnd_en=1.
  - DONE: done=1.
- Transitions:
  - IDLE→EXPAND on start. dir is latched into dir_q on the same edge.
  - EXPAND→INIT when kx_word==NW-1.
  - INIT→ROUND.
  - ROUND→FINAL after NR-1 cycles.
  - FINAL→DONE.
  - DONE→IDLE on a synchronized load rising edge; done drops the same cycle IDLE is entered.
  - A new start while in DONE is impossible, since a rise must precede it.
- Cycle numbering: cycle 0 is the first EXPAND cycle, which is 3 clk edges after load is first sampled low.
  - EXPAND spans NW-NK cycles: 40 / 46 / 52.
  - INIT is at cycle NW-NK.
  - done first high at cycle NW-NK+NR+1: K=128 → 51, K=192 → 59, K=256 → 67.
- rk_idx:
  - dir_q=1 (decrypt): INIT = NR; ROUND = NR-1 down to 1; FINAL = 0.
  - dir_q=0 (encrypt): INIT = 0; ROUND = 1 up to NR-1; FINAL = NR.
  - rk_idx is 0 outside INIT/ROUND/FINAL.
- Output timing and idle values:
  - All outputs are registered (Moore) and change only on clk edges.
  - kx_word holds its last value outside EXPAND; kx_en=0 there.
  - busy=1 in EXPAND, INIT, ROUND and FINAL; busy=0 in IDLE and DONE.
- Abort: a synchronized load rising edge in EXPAND, INIT, ROUND or FINAL returns the FSM to IDLE on the next edge.
  - All enables drop and done stays 0.
  - The next falling edge restarts from kx_word=NK.
- dir changes after start are ignored until the next start.
- Reset asserted mid-operation forces IDLE immediately, independent of clk.
- Counters are sized to NW-1 (6 bits) and never wrap; equality compares are against the derived constants.

Test Plan:
1. K=128, dir=1: load high 10 cycles then low → kx_word 4..43 over cycles 0-39; INIT at cycle 40 with rk_idx=10; ROUND rk_idx 9..1; FINAL at cycle 50 with rk_idx=0 and last=1; done=1 from cycle 51 until load rises.
2. K=256, dir=0 → EXPAND kx_word 8..59 (52 cycles); rk_idx sequence 0,1..13,14; done first high at cycle 67; busy high on cycles 0-66 only.
3. K=192, dir=1: load rises at cycle 20 (mid-EXPAND) → FSM in IDLE 3 edges later; kx_en=0; done never asserts. Load falls again → kx_word restarts at 6; done at cycle 59 of the new run.
4. Reset asserted at cycle 45 of a K=128 run (inside ROUND) → all outputs 0 without waiting for a clk edge; after reset release, a fresh load pulse completes normally with done at cycle 51.
5. K=128: dir toggled every cycle after start, with dir=1 at the latch edge → rk_idx strictly descending 10..0; result is unaffected by the toggling.
6. load held high indefinitely after reset → FSM stays in IDLE; all outputs 0; no start until the falling edge.
